simd_alu_scheduler: RTL and testbench
=====================================

// Module: simd_alu_scheduler
// PURPOSE
//  Shares one SIMD_ALU_Extended instance between NUM_REQ requesters. Round-robin arbitration,
//  one vector op in flight at a time. Accepted operands/opcodes are registered and issued to
//  the ALU with a one-cycle en pulse. The ALU result and flags are captured ALU_LATENCY cycles
//  later and returned on a valid/ready response channel tagged with the requester ID.
// PARAMETERS
//  NUM_REQ        4   requesters sharing the ALU (>=2)
//  DATA_WIDTH     32  lane width
//  OP_WIDTH       5   per-lane opcode width
//  SIMD_WIDTH     4   lanes per op
//  ALU_LATENCY    1   cycles from the en cycle to valid ALU outputs (>=1)
//  NUM_VALID_OPS  24  opcodes 0..NUM_VALID_OPS-1 are legal (used only with the opcode check)
// PORTS
//  clk            in   1                        clock, all logic on posedge
//  rst            in   1                        asynchronous reset, active-high
//  req_valid      in   NUM_REQ                  per-requester op valid
//  req_ready      out  NUM_REQ                  one-hot accept, asserted in the accept cycle only
//  req_operand_a  in   NUM_REQ*SIMD_WIDTH*DATA_WIDTH  packed per requester
//  req_operand_b  in   NUM_REQ*SIMD_WIDTH*DATA_WIDTH
//  req_alu_op     in   NUM_REQ*SIMD_WIDTH*OP_WIDTH
//  alu_operand_a  out  SIMD_WIDTH*DATA_WIDTH    to ALU, registered
//  alu_operand_b  out  SIMD_WIDTH*DATA_WIDTH
//  alu_op         out  SIMD_WIDTH*OP_WIDTH
//  alu_en         out  1                        one-cycle issue pulse
//  alu_result     in   SIMD_WIDTH*DATA_WIDTH    from ALU
//  alu_flags      in   4*SIMD_WIDTH             {negative,carry_out,overflow,zero}, SIMD_WIDTH each
//  rsp_valid      out  1                        response valid, held until rsp_ready
//  rsp_ready      in   1
//  rsp_id         out  $clog2(NUM_REQ)          requester index of the response
//  rsp_result     out  SIMD_WIDTH*DATA_WIDTH
//  rsp_flags      out  4*SIMD_WIDTH
//  rsp_err        out  1                        illegal opcode; always 0 without the check
//  busy           out  1                        state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, all outputs and holding registers 0. Reset mid-operation
//   discards the in-flight op; no response is produced for it.
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   IDLE: when any req_valid is set, grant the first set bit at or after rr_ptr (wrapping).
//    Assert req_ready[g] combinationally this cycle, latch operands/opcodes/id, set
//    rr_ptr=(g+1)%NUM_REQ, go to ISSUE. Nothing is accepted while the state is not IDLE.
//   ISSUE: alu_en=1 for exactly this cycle, cnt=ALU_LATENCY-1, go to WAIT.
//   WAIT: when cnt==0, capture alu_result/alu_flags into rsp_* and go to RESP; else cnt--.
//   RESP: rsp_valid=1. rsp_* are stable until the rsp_valid&&rsp_ready cycle, then go to IDLE.
//  Accept to rsp_valid = ALU_LATENCY+2 cycles. Minimum op spacing = ALU_LATENCY+3 cycles.
//  alu_operand_*/alu_op hold their last value outside ISSUE; alu_en=0 except in ISSUE.
//  A requester dropping req_valid before grant is legal; a grant only occurs on the current valid.
//  rsp_ready held high in RESP: return to IDLE next cycle; a new accept can occur in that IDLE cycle.
// CONFIGURATION
//  SIMD_SCHED_OPCHECK_EN defined: in the accept cycle, if any lane opcode >= NUM_VALID_OPS, the op
//   bypasses ISSUE/WAIT and goes IDLE->RESP next cycle: rsp_err=1, rsp_result=0, rsp_flags=0,
//   and no alu_en pulse. Arbitration and rr_ptr update are unchanged.
//  Not defined: no opcode check, rsp_err tied 0, every accepted op is issued.
// STRUCTURE
//  Package simd_sched_pkg: state_e enum {IDLE,ISSUE,WAIT,RESP}; FLAG_W=4; flag bit
//   index constants; lane slice helper functions.
//  Sub-module rr_arbiter (NUM_REQ, req vector + ptr -> one-hot grant + index); the rest is inline.
// TESTING
//  Single op: req_valid[2]=1, lanes a=5,b=3, op=ADD, ALU_LATENCY=1 -> req_ready[2] one cycle,
//   one alu_en pulse, rsp_valid 3 cycles after accept, rsp_id=2, lanes=8.
//  Fairness: all four req_valid held high for 8 ops -> grant order 0,1,2,3,0,1,2,3.
//  Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, no new req_ready, busy=1.
//  Reset mid-op: rst asserted during WAIT -> next cycle IDLE, rsp_valid=0, rr_ptr=0,
//   no stale response after reset release.
//  Latency: ALU_LATENCY=3 -> capture exactly 3 cycles after the alu_en cycle; scoreboard vs model.
//  Opcode check with SIMD_SCHED_OPCHECK_EN: lane op=30 -> no alu_en, rsp_err=1, rsp_result=0,
//   response 1 cycle after accept. Without the macro: the same op is issued and rsp_err=0.

Source files
------------

// File: rtl/simd_sched_pkg.sv
// Shared types and helpers for the SIMD ALU scheduler: FSM state encoding,
// flag-field layout and lane slicing offsets.
package simd_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // alu_flags is {negative, carry_out, overflow, zero}, each SIMD_WIDTH wide
    localparam int FLAG_W     = 4;
    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_OVF   = 1;
    localparam int FLAG_CARRY = 2;
    localparam int FLAG_NEG   = 3;

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

    function automatic int req_lane_lsb(input int req, input int lane, input int lanes, input int width);
        return (req * lanes + lane) * width;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or after ptr,
// wrapping around, as a one-hot vector plus its index.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] pos;

    // Scan from the farthest offset down so the nearest request wins last.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        sum   = '0;
        pos   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            pos = sum[IDX_W-1:0];
            if (req[pos]) begin
                grant      = '0;
                grant[pos] = 1'b1;
                idx        = pos;
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/simd_alu_scheduler.sv
// Shares one SIMD ALU between NUM_REQ requesters with round-robin arbitration and
// a single op in flight. Optional illegal-opcode bypass: SIMD_SCHED_OPCHECK_EN.
module simd_alu_scheduler
    import simd_sched_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int OP_WIDTH      = 5,
    parameter int SIMD_WIDTH    = 4,
    parameter int ALU_LATENCY   = 1,
    parameter int NUM_VALID_OPS = 24,
    localparam int ID_W  = $clog2(NUM_REQ),
    localparam int VEC_W = SIMD_WIDTH * DATA_WIDTH,
    localparam int OPV_W = SIMD_WIDTH * OP_WIDTH,
    localparam int FLG_W = FLAG_W * SIMD_WIDTH,
    localparam int CNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*VEC_W-1:0]   req_operand_a,
    input  logic [NUM_REQ*VEC_W-1:0]   req_operand_b,
    input  logic [NUM_REQ*OPV_W-1:0]   req_alu_op,
    output logic [VEC_W-1:0]           alu_operand_a,
    output logic [VEC_W-1:0]           alu_operand_b,
    output logic [OPV_W-1:0]           alu_op,
    output logic                       alu_en,
    input  logic [VEC_W-1:0]           alu_result,
    input  logic [FLG_W-1:0]           alu_flags,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [VEC_W-1:0]           rsp_result,
    output logic [FLG_W-1:0]           rsp_flags,
    output logic                       rsp_err,
    output logic                       busy
);

    localparam logic [OP_WIDTH:0] OP_LIMIT = (OP_WIDTH+1)'(NUM_VALID_OPS);

    state_e             state_reg, state_next;
    logic [ID_W-1:0]    rr_ptr_reg, id_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [VEC_W-1:0]   a_reg, b_reg, rsp_result_reg;
    logic [OPV_W-1:0]   op_reg;
    logic [FLG_W-1:0]   rsp_flags_reg;
    logic               rsp_err_reg;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any, accept_err;
    logic [VEC_W-1:0]   sel_a, sel_b;
    logic [OPV_W-1:0]   sel_op;
    logic [SIMD_WIDTH-1:0] lane_bad;

    // Requests are only visible to the arbiter while idle, so req_ready doubles as accept.
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (req_valid & {NUM_REQ{state_reg == IDLE}}),
        .ptr   (rr_ptr_reg),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    assign req_ready = grant;
    assign sel_a     = req_operand_a[grant_idx*VEC_W +: VEC_W];
    assign sel_b     = req_operand_b[grant_idx*VEC_W +: VEC_W];
    assign sel_op    = req_alu_op[grant_idx*OPV_W +: OPV_W];

    for (genvar gi = 0; gi < SIMD_WIDTH; gi++) begin : g_lane_chk
        assign lane_bad[gi] = {1'b0, sel_op[lane_lsb(gi, OP_WIDTH) +: OP_WIDTH]} >= OP_LIMIT;
    end

`ifdef SIMD_SCHED_OPCHECK_EN
    assign accept_err = grant_any && (|lane_bad);
`else
    logic unused_lane_bad;
    assign unused_lane_bad = |lane_bad;
    assign accept_err      = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_any) state_next = accept_err ? RESP : ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (cnt_reg == '0) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            rr_ptr_reg     <= '0;
            id_reg         <= '0;
            cnt_reg        <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            op_reg         <= '0;
            rsp_result_reg <= '0;
            rsp_flags_reg  <= '0;
            rsp_err_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: if (grant_any) begin
                    id_reg     <= grant_idx;
                    rr_ptr_reg <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
                    if (accept_err) begin
                        rsp_result_reg <= '0;
                        rsp_flags_reg  <= '0;
                        rsp_err_reg    <= 1'b1;
                    end else begin
                        // Operands only move for ops that really go to the ALU.
                        a_reg  <= sel_a;
                        b_reg  <= sel_b;
                        op_reg <= sel_op;
                    end
                end
                ISSUE: cnt_reg <= CNT_W'(ALU_LATENCY - 1);
                WAIT: begin
                    if (cnt_reg == '0) begin
                        rsp_result_reg <= alu_result;
                        rsp_flags_reg  <= alu_flags;
                        rsp_err_reg    <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_operand_a = a_reg;
    assign alu_operand_b = b_reg;
    assign alu_op        = op_reg;
    assign alu_en        = (state_reg == ISSUE);
    assign rsp_valid     = (state_reg == RESP);
    assign rsp_id        = id_reg;
    assign rsp_result    = rsp_result_reg;
    assign rsp_flags     = rsp_flags_reg;
    assign rsp_err       = rsp_err_reg;
    assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_simd_alu_scheduler.sv
// Bench for simd_alu_scheduler: two instances (ALU latency 1 and 3) share request
// stimulus; each drives a stand-in ALU that outputs junk except in its valid cycle.
module tb_simd_alu_scheduler;
    import simd_sched_pkg::*;

    localparam int NR = 4, DW = 32, OW = 5, SW = 4, NVO = 24;
    localparam int VW = SW * DW, OVW = SW * OW, FW = FLAG_W * SW;
`ifdef SIMD_SCHED_OPCHECK_EN
    localparam bit OPCHK = 1'b1;
`else
    localparam bit OPCHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NR-1:0]     req_valid = '0;
    logic [NR*VW-1:0]  req_a = '0, req_b = '0;
    logic [NR*OVW-1:0] req_op = '0;
    logic [NR-1:0]     req_ready_d [2];
    logic [VW-1:0]     alu_a_d [2], alu_b_d [2], alu_res_d [2], rsp_res_d [2];
    logic [OVW-1:0]    alu_op_d [2];
    logic [FW-1:0]     alu_flg_d [2], rsp_flg_d [2];
    logic [1:0]        rsp_id_d [2];
    logic [1:0]        alu_en_d, rsp_valid_d, rsp_err_d, busy_d;
    logic [1:0]        rsp_ready_d = '0;

    int checks = 0;
    int errors = 0;
    int rr_model = 0;

    // Stand-in lane ALU: result and flags for a given opcode.
    function automatic logic [FW+VW-1:0] alu_vec(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                                 input logic [OVW-1:0] op);
        logic [VW-1:0] r;
        logic [FW-1:0] f;
        logic [DW:0]   s;
        logic [DW-1:0] la, lb, lr;
        logic [OW-1:0] lo;
        r = '0;
        f = '0;
        for (int l = 0; l < SW; l++) begin
            la = a[l*DW +: DW];
            lb = b[l*DW +: DW];
            lo = op[l*OW +: OW];
            case (lo)
                5'd0:    s = {1'b0, la} + {1'b0, lb};
                5'd1:    s = {1'b0, la} - {1'b0, lb};
                5'd2:    s = {1'b0, la & lb};
                5'd3:    s = {1'b0, la | lb};
                default: s = {1'b0, la ^ DW'(lo)};
            endcase
            lr = s[DW-1:0];
            r[l*DW +: DW]         = lr;
            f[FLAG_NEG*SW + l]    = lr[DW-1];
            f[FLAG_CARRY*SW + l]  = s[DW];
            f[FLAG_OVF*SW + l]    = ^lr;
            f[FLAG_ZERO*SW + l]   = (lr == '0);
        end
        return {f, r};
    endfunction

    function automatic logic [FW+VW-1:0] junk();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int LAT = (gi == 0) ? 1 : 3;
        logic [FW+VW-1:0] pipe [LAT];

        simd_alu_scheduler #(
            .NUM_REQ(NR), .DATA_WIDTH(DW), .OP_WIDTH(OW), .SIMD_WIDTH(SW),
            .ALU_LATENCY(LAT), .NUM_VALID_OPS(NVO)
        ) dut (
            .clk(clk), .rst(rst),
            .req_valid(req_valid), .req_ready(req_ready_d[gi]),
            .req_operand_a(req_a), .req_operand_b(req_b), .req_alu_op(req_op),
            .alu_operand_a(alu_a_d[gi]), .alu_operand_b(alu_b_d[gi]), .alu_op(alu_op_d[gi]),
            .alu_en(alu_en_d[gi]), .alu_result(alu_res_d[gi]), .alu_flags(alu_flg_d[gi]),
            .rsp_valid(rsp_valid_d[gi]), .rsp_ready(rsp_ready_d[gi]), .rsp_id(rsp_id_d[gi]),
            .rsp_result(rsp_res_d[gi]), .rsp_flags(rsp_flg_d[gi]), .rsp_err(rsp_err_d[gi]),
            .busy(busy_d[gi])
        );

        // Output is correct only LAT cycles after the en cycle, junk otherwise.
        always @(posedge clk) begin
            pipe[0] <= alu_en_d[gi] ? alu_vec(alu_a_d[gi], alu_b_d[gi], alu_op_d[gi]) : junk();
            for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
        end
        assign {alu_flg_d[gi], alu_res_d[gi]} = pipe[LAT-1];
    end

    task automatic chk(input string name, input int d, input logic [FW+VW-1:0] act,
                       input logic [FW+VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (lat%0d): got %0h expected %0h", name, (d == 0) ? 1 : 3, act, exp);
        end
    endtask

    // Round-robin reference: first valid requester at or after the pointer.
    function automatic int model_grant(input logic [NR-1:0] valid);
        int g;
        g = -1;
        for (int i = 0; i < NR; i++) begin
            if (g < 0 && valid[(rr_model + i) % NR]) g = (rr_model + i) % NR;
        end
        if (g >= 0) rr_model = (g + 1) % NR;
        return g;
    endfunction

    task automatic do_op(input logic [NR-1:0] valid, input logic [NR*VW-1:0] a,
                         input logic [NR*VW-1:0] b, input logic [NR*OVW-1:0] op,
                         input int delay, input bit hold, input int exp_id,
                         input logic [VW-1:0] exp_res, input logic [FW-1:0] exp_flg,
                         input bit exp_err);
        int en_cnt [2], en_cyc [2], rsp_cyc [2], stab_err [2], extra_rdy [2];
        bit seen [2], pend [2], done [2];
        logic [VW-1:0] cap_res [2];
        logic [FW-1:0] cap_flg [2];
        logic [1:0]    cap_id [2];
        logic          cap_err [2];
        for (int d = 0; d < 2; d++) begin
            en_cnt[d] = 0; en_cyc[d] = -1; rsp_cyc[d] = -1; stab_err[d] = 0; extra_rdy[d] = 0;
            seen[d] = 0; pend[d] = 0; done[d] = 0;
            cap_res[d] = '0; cap_flg[d] = '0; cap_id[d] = '0; cap_err[d] = 1'b0;
        end
        req_valid = valid; req_a = a; req_b = b; req_op = op;
        #1;
        for (int d = 0; d < 2; d++) chk("accept_ready", d, req_ready_d[d], NR'(1) << exp_id);
        for (int cyc = 1; cyc <= 40 && !(done[0] && done[1]); cyc++) begin
            @(negedge clk);
            if (!hold) req_valid = '0;
            for (int d = 0; d < 2; d++) begin
                if (pend[d]) begin
                    done[d] = 1; pend[d] = 0; rsp_ready_d[d] = 1'b0;
                    if (rsp_valid_d[d] || busy_d[d]) stab_err[d]++;
                end else if (!done[d]) begin
                    if (alu_en_d[d]) begin en_cnt[d]++; en_cyc[d] = cyc; end
                    if (rsp_valid_d[d]) begin
                        if (!seen[d]) begin
                            seen[d] = 1; rsp_cyc[d] = cyc;
                            cap_res[d] = rsp_res_d[d]; cap_flg[d] = rsp_flg_d[d];
                            cap_id[d] = rsp_id_d[d]; cap_err[d] = rsp_err_d[d];
                        end else if (rsp_res_d[d] !== cap_res[d] || rsp_flg_d[d] !== cap_flg[d] ||
                                     rsp_id_d[d] !== cap_id[d] || rsp_err_d[d] !== cap_err[d]) begin
                            stab_err[d]++;
                        end
                        if (busy_d[d] !== 1'b1) stab_err[d]++;
                        if (cyc - rsp_cyc[d] >= delay) begin
                            rsp_ready_d[d] = 1'b1; pend[d] = 1; req_valid = '0;
                        end
                    end
                end
                if (req_ready_d[d] != '0) extra_rdy[d]++;
            end
        end
        for (int d = 0; d < 2; d++) begin
            chk("completed", d, done[d], 1);
            chk("alu_en_count", d, en_cnt[d], exp_err ? 0 : 1);
            if (!exp_err) chk("alu_en_cycle", d, en_cyc[d], 1);
            chk("rsp_latency", d, rsp_cyc[d], exp_err ? 1 : ((d == 0) ? 3 : 5));
            chk("rsp_id", d, cap_id[d], exp_id);
            chk("rsp_result", d, cap_res[d], exp_res);
            chk("rsp_flags", d, cap_flg[d], exp_flg);
            chk("rsp_err", d, cap_err[d], exp_err);
            chk("rsp_stable", d, stab_err[d], 0);
            chk("no_extra_ready", d, extra_rdy[d], 0);
        end
        $display("op valid=%b id=%0d err=%0d res=%0h delay=%0d hold=%0d lat1_at=%0d lat3_at=%0d",
                 valid, cap_id[0], cap_err[0], cap_res[0], delay, hold, rsp_cyc[0], rsp_cyc[1]);
    endtask

    typedef struct {
        logic [NR-1:0] valid;
        logic [DW-1:0] a, b;
        logic [OW-1:0] op;
        int            delay;
        bit            hold;
        int            exp_id;
        logic [DW-1:0] exp_lane;
        bit            exp_err;
    } vec_t;

    vec_t tbl [11];

    initial begin
        logic [FW+VW-1:0] tmp;
        logic [VW-1:0]    ga, gb;
        logic [OVW-1:0]   gop;
        logic [NR*VW-1:0] ra, rb;
        logic [NR*OVW-1:0] rop;
        logic [NR-1:0]    v;
        int g, stale;
        bit bad;

        tbl[0] = '{4'b0100, 32'd5, 32'd3, 5'd0, 0, 1'b0, 2, 32'd8, 1'b0};
        for (int k = 1; k <= 8; k++)
            tbl[k] = '{4'b1111, DW'(k), 32'd100, 5'd0, k % 3, 1'b1, (k + 2) % 4, DW'(100 + k), 1'b0};
        tbl[9]  = '{4'b0011, 32'd7, 32'd9, 5'd1, 5, 1'b1, 0, 32'hFFFF_FFFE, 1'b0};
        tbl[10] = '{4'b1000, 32'd1, 32'd2, 5'd30, 0, 1'b0, 3, OPCHK ? 32'd0 : 32'd31, OPCHK};

        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_busy", d, busy_d[d], 0);
            chk("reset_rsp_valid", d, rsp_valid_d[d], 0);
            chk("reset_alu_en", d, alu_en_d[d], 0);
            chk("reset_rsp_result", d, rsp_res_d[d], 0);
            chk("reset_alu_operand_a", d, alu_a_d[d], 0);
            chk("reset_rsp_id_err", d, {rsp_id_d[d], rsp_err_d[d]}, 0);
            chk("reset_req_ready", d, req_ready_d[d], 0);
        end
        rst = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 11; t++) begin
            ra  = {(NR*SW){tbl[t].a}};
            rb  = {(NR*SW){tbl[t].b}};
            rop = {(NR*SW){tbl[t].op}};
            tmp = alu_vec(ra[VW-1:0], rb[VW-1:0], rop[OVW-1:0]);
            g = model_grant(tbl[t].valid);
            do_op(tbl[t].valid, ra, rb, rop, tbl[t].delay, tbl[t].hold, tbl[t].exp_id,
                  {SW{tbl[t].exp_lane}}, tbl[t].exp_err ? '0 : tmp[VW +: FW], tbl[t].exp_err);
        end

        // Reset while the op sits in WAIT: no response, pointer back to 0.
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("midop_reset_busy", d, busy_d[d], 0);
            chk("midop_reset_rsp_valid", d, rsp_valid_d[d], 0);
        end
        @(negedge clk);
        rst = 1'b0;
        rsp_ready_d = 2'b11;
        for (int d = 0; d < 2; d++) begin
            stale = 0;
            for (int c = 0; c < 8; c++) begin
                if (d == 0) @(negedge clk);
                if (rsp_valid_d[d] || alu_en_d[d] || busy_d[d]) stale++;
            end
            chk("no_stale_after_reset", d, stale, 0);
        end
        rsp_ready_d = '0;
        rr_model = 0;

        for (int n = 0; n < 40; n++) begin
            v = NR'($urandom_range(1, (1 << NR) - 1));
            for (int r = 0; r < NR; r++) begin
                for (int l = 0; l < SW; l++) begin
                    ra[req_lane_lsb(r, l, SW, DW) +: DW]  = $urandom;
                    rb[req_lane_lsb(r, l, SW, DW) +: DW]  = $urandom;
                    rop[req_lane_lsb(r, l, SW, OW) +: OW] = ($urandom_range(0, 11) == 0) ?
                        OW'($urandom_range(NVO, 31)) : OW'($urandom_range(0, NVO - 1));
                end
            end
            g   = model_grant(v);
            ga  = ra[g*VW +: VW];
            gb  = rb[g*VW +: VW];
            gop = rop[g*OVW +: OVW];
            bad = 0;
            for (int l = 0; l < SW; l++) if (int'(gop[l*OW +: OW]) >= NVO) bad = 1;
            bad = bad && OPCHK;
            tmp = bad ? '0 : alu_vec(ga, gb, gop);
            do_op(v, ra, rb, rop, $urandom_range(0, 3), 1'($urandom_range(0, 1)), g,
                  tmp[VW-1:0], tmp[VW +: FW], bad);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
